irq_event_latch_4: RTL
======================

Name: irq_event_latch_4

Overview:
- Upstream stage of orgate_4.
- Converts four raw event lines into sticky, maskable pending flags.
- pend[3:0] drives orgate_4 inputs a..d, so orgate_4.y forms the combined interrupt.
- Also provides a lowest-index-first valid/ack handshake so a consumer can service and clear events one at a time, and counts events lost to an already-pending flag.

Parameters:
- CNT_W, 4, width of per-channel saturating missed-event counter.
- SYNC_STAGES, 2, flops per input in the optional synchronizer (legal 2..4); ignored unless EVLATCH_SYNC_EN is defined.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ev_in  input  4  raw event lines; an event is a 0->1 transition.
- mask  input  4  1 = channel enabled for pend/irq.
- clr  input  4  write-1-to-clear per channel (pending and missed counter).
- irq_ack  input  1  consumer accepts the offered id.
- pend  output  4  pending & mask; bits 0..3 go to orgate_4 a,b,c,d.
- irq_valid  output  1  an id is being offered.
- irq_id  output  2  offered channel index.
- miss_cnt  output  4*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rst=1 at a clock edge) clears everything. After it: pending=0, pend=0, irq_valid=0, irq_id=0, miss_cnt=0, edge-history flops=0, FSM=IDLE. Reset mid-handshake abandons the offer.
- Edge detect: rise[i] = s[i] & ~s_q[i], where s is ev_in (or its synchronized copy) and s_q is s delayed one cycle.
  - A line already high when reset deasserts produces one event.
  - A level held high produces only one event.
- Latency: ev_in sampled high at edge k, low at edge k-1 -> pending[i]=1 after edge k, and pend[i] is visible then if masked in. With EVLATCH_SYNC_EN, add SYNC_STAGES cycles.
- Pending update priority per channel, highest first:
  1. rst.
  2. rise sets pending. Set wins over clr and over ack-clear in the same cycle.
  3. clr[i] clears pending.
  4. ack-clear clears pending.
- Missed counter: rise[i] while pending[i]=1 and no clear that cycle -> miss_cnt[i]+1, saturating at 2^CNT_W-1. clr[i] zeroes the counter even if a rise occurs the same cycle.
- Masking: mask gates only pend and the handshake. Pending still latches and counts while masked. Unmasking exposes the stored event the next cycle.
- pend is combinational from the pending register and mask; there are no combinational paths from ev_in or irq_ack.
- Handshake FSM, two states:
  - IDLE: irq_valid=0. If |pend, latch irq_id = lowest set index of pend, then go to OFFER with irq_valid=1.
  - OFFER: irq_id held stable, even if a lower-index channel becomes pending.
    - irq_ack=1 -> clear pending[irq_id] (unless a rise on that channel at the same edge), go to IDLE.
    - pend[irq_id] drops (masked or clr) -> withdraw: go to IDLE, irq_valid=0.
  - irq_ack in IDLE is ignored.
- Throughput: one serviced event per 2 cycles minimum, because IDLE always inserts one bubble.

Optional Feature:
- Macro: EVLATCH_SYNC_EN.
- Defined: each ev_in bit passes through a SYNC_STAGES-deep flop chain, reset to 0, before edge detection. Use this for asynchronous sources.
- Undefined: ev_in is treated as synchronous to clk and feeds edge detection directly. The SYNC_STAGES parameter has no effect.
- All other behaviour is identical in both builds; only latency changes.

Decomposition:
- Package evl_pkg holds:
  - NUM_CH=4, ID_W=2.
  - FSM state enum {IDLE, OFFER}.
  - A lowest-set-index function.
- Sub-module evl_edge_sync: one channel's optional synchronizer plus edge detector, outputting rise. Instantiated NUM_CH times.
- Pending, counters, FSM and priority select stay in the top.

Test Plan (default parameters, macro undefined unless noted):
- Reset: hold rst 3 cycles with ev_in=4'b1010 -> all outputs 0. After release: pending=4'b1010 one edge later, irq_valid=1 the following cycle with irq_id=1.
- Priority and stability: mask=4'hF. Pulse ev_in[2], wait for the offer (irq_id=2), then pulse ev_in[0] -> irq_id stays 2 until irq_ack. After ack: IDLE one cycle, then irq_id=0 offered; pend goes 4'b0101 -> 4'b0001 -> 0.
- Missed counter: 20 rising edges on ev_in[3] with no ack -> miss_cnt[3] saturates at 15, pending[3]=1. clr=4'b1000 -> counter=0, pending[3]=0, orgate_4.y=0.
- Collision: rise on ev_in[1] in the same cycle as irq_ack for id 1 -> pending[1] stays 1, miss_cnt[1] unchanged, re-offered after one bubble.
- Mask and withdraw: offer id 0, then drop mask[0] before ack -> irq_valid falls next cycle and pending[0] stays 1. Restore mask -> re-offered.
- Build with EVLATCH_SYNC_EN, SYNC_STAGES=3: single ev_in[0] rise -> pending[0] set exactly 3 cycles later than in the unsynchronized build.

Source files
------------

// File: rtl/evl_pkg.sv
// ----------------------------------------------------------------------------
// Module   : evl_pkg
// Brief    : Shared constants, FSM state type and lowest-index helper for the
//            irq_event_latch_4 event latch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package evl_pkg;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } evl_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/evl_edge_sync.sv
// ----------------------------------------------------------------------------
// Module   : evl_edge_sync
// Brief    : One event channel: optional input synchronizer followed by a
//            rising-edge detector. rise is combinational from the (possibly
//            synchronized) line and its one-cycle-delayed copy.
//            Macro EVLATCH_SYNC_EN inserts a SYNC_STAGES-deep flop chain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module evl_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  output logic rise
);

  logic w_s;
  logic r_s_q;

`ifdef EVLATCH_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], ev};
  end

  assign w_s = r_sync[SYNC_STAGES-1];
`else
  // Line is already synchronous; the stage count does not change anything
  // here, both arms are the same direct connection.
  generate
    if (SYNC_STAGES > 0) begin : g_direct
      assign w_s = ev;
    end else begin : g_direct_zero
      assign w_s = ev;
    end
  endgenerate
`endif

  // Edge history; cleared by reset so a line high at release yields one event.
  always_ff @(posedge clk) begin
    if (rst) r_s_q <= 1'b0;
    else     r_s_q <= w_s;
  end

  assign rise = w_s & ~r_s_q;

endmodule

`default_nettype wire

// File: rtl/irq_event_latch_4.sv
// ----------------------------------------------------------------------------
// Module   : irq_event_latch_4
// Brief    : Four-channel sticky, maskable event latch with saturating
//            missed-event counters and a lowest-index-first valid/ack offer.
//            pend[3:0] feeds orgate_4 inputs a..d.
//            Macro EVLATCH_SYNC_EN enables per-input synchronizers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module irq_event_latch_4
  import evl_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          ev_in,
  input  logic [3:0]          mask,
  input  logic [3:0]          clr,
  input  logic                irq_ack,
  output logic [3:0]          pend,
  output logic                irq_valid,
  output logic [1:0]          irq_id,
  output logic [4*CNT_W-1:0]  miss_cnt
);

  logic [NUM_CH-1:0]             w_rise;
  logic [NUM_CH-1:0]             w_ack_clr;
  logic [NUM_CH-1:0]             r_pending;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_miss;
  evl_state_t                    r_state;
  logic                          r_valid;
  logic [ID_W-1:0]               r_id;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      evl_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .ev   (ev_in[g]),
        .rise (w_rise[g])
      );
    end
  endgenerate

  // An accepted offer clears the channel currently being offered.
  always_comb begin
    w_ack_clr = '0;
    if (r_state == OFFER && irq_ack) w_ack_clr[r_id] = 1'b1;
  end

  assign pend = r_pending & mask;

  // Pending flags and missed counters: rise beats clr beats ack-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_miss    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_rise[i])         r_pending[i] <= 1'b1;
        else if (clr[i])       r_pending[i] <= 1'b0;
        else if (w_ack_clr[i]) r_pending[i] <= 1'b0;

        if (clr[i]) begin
          r_miss[i] <= '0;
        end else if (w_rise[i] && r_pending[i] && !w_ack_clr[i]
                     && r_miss[i] != {CNT_W{1'b1}}) begin
          r_miss[i] <= r_miss[i] + CNT_W'(1);
        end
      end
    end
  end

  // Offer FSM: IDLE picks the lowest pending index, OFFER holds it until
  // acked or until that channel stops being visible in pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|pend) begin
            r_id    <= lowest_idx(pend);
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ack || !pend[r_id]) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign miss_cnt  = r_miss;

endmodule

`default_nettype wire
